// File: rtl/morse_pkg.sv
// Shared constants for the morse panel peripherals.
// Holds the bus window base address, the register offsets inside the
// input window, the constant ID word, and the bit position of each
// button inside the LEVELS and EVENTS registers.
package morse_pkg;

  // First address of the 4-word input window. It sits directly above
  // the morse output window on the same address bus.
  localparam logic [15:0] BASE_ADDR = 16'he664;

  // Word offsets inside the window
  localparam logic [1:0] OFF_LEVELS = 2'd0;
  localparam logic [1:0] OFF_EVENTS = 2'd1;
  localparam logic [1:0] OFF_FREQ   = 2'd2;
  localparam logic [1:0] OFF_ID     = 2'd3;

  // "MS" in ASCII, lets software confirm the block is present
  localparam logic [15:0] ID_VALUE = 16'h4D53;

  // Bit index of each button in LEVELS and EVENTS
  localparam int EV_LEFT  = 0;
  localparam int EV_RIGHT = 1;
  localparam int EV_TX    = 2;

  localparam int NUM_BUTTONS = 3;

endpackage

// File: rtl/morse_input_mem_debounce.sv
// Single-button input conditioner.
// A raw asynchronous button goes through a 2-FF synchronizer, then a
// counter that must see DEBOUNCE_CYCLES consecutive samples differing
// from the current debounced level before that level toggles. A
// one-cycle press pulse accompanies every rising change of the level.
//
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-high reset
//   btn    - raw button, active-high, asynchronous to clk
//   level  - debounced button level
//   press  - one-cycle pulse, high in the first cycle level reads 1
module morse_input_mem_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_out;
  logic [CNT_W-1:0] cnt;

  // Any sample that agrees with the current level restarts the count,
  // so only an uninterrupted run of differing samples can toggle the
  // level. The press pulse is produced in the same edge as the toggle
  // so it lines up with the first cycle of the new high level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
      level     <= 1'b0;
      cnt       <= '0;
      press     <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync_out  <= sync_meta;
      press     <= 1'b0;
      if (sync_out == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
        press <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_input_mem.sv
// Memory-mapped read-side peripheral of the morse module.
// Debounces the LEFT, RIGHT and TX panel buttons, keeps sticky press
// flags and a saturating frequency-selector index, and returns the
// register contents on the shared bus with one cycle of read latency.
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous, active-high reset
//   addr       - bus address
//   data       - bus write data (only used for write-1-to-clear)
//   en         - bus cycle enable
//   we         - 1 = write, 0 = read
//   btn_left   - raw LEFT button
//   btn_right  - raw RIGHT button
//   btn_tx     - raw TX button
//   q          - registered read data
//   irq        - high while any event flag is set (registered)
module morse_input_mem
  import morse_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 16,
  parameter int                    ADDR_WIDTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = ADDR_WIDTH'(morse_pkg::BASE_ADDR),
  parameter int                    DEBOUNCE_CYCLES = 50000,
  parameter int                    FREQ_MAX        = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  en,
  input  logic                  we,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  btn_tx,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  irq
);

  localparam int FREQ_W = (FREQ_MAX > 1) ? $clog2(FREQ_MAX + 1) : 1;
  localparam logic [FREQ_W-1:0] FREQ_LAST = FREQ_W'(FREQ_MAX);

  logic [NUM_BUTTONS-1:0] btn_raw;
  logic [NUM_BUTTONS-1:0] levels;
  logic [NUM_BUTTONS-1:0] presses;
  logic [NUM_BUTTONS-1:0] flags;
  logic [NUM_BUTTONS-1:0] clr_mask;
  logic [FREQ_W-1:0]      freq_idx;
  logic [ADDR_WIDTH-1:0]  offset;
  logic                   in_window;
  logic                   hit_events;
  logic                   rd;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   unused_data_bits;

  assign btn_raw = {btn_tx, btn_right, btn_left};

  genvar i;
  for (i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    morse_input_mem_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .btn  (btn_raw[i]),
      .level(levels[i]),
      .press(presses[i])
    );
  end

  // Subtracting the base makes addresses below the window wrap to large
  // values, so a single compare covers both ends of the range.
  assign offset     = addr - BASE_ADDR;
  assign in_window  = (offset < ADDR_WIDTH'(4));
  assign hit_events = in_window && (offset[1:0] == OFF_EVENTS);
  assign rd         = en && !we;

  // Only the low event bits of the write data matter
  assign unused_data_bits = ^data[DATA_WIDTH-1:NUM_BUTTONS];

  always_comb begin
    rd_data = '0;
    if (in_window) begin
      case (offset[1:0])
        OFF_LEVELS: rd_data[NUM_BUTTONS-1:0] = levels;
        OFF_EVENTS: rd_data[NUM_BUTTONS-1:0] = flags;
        OFF_FREQ:   rd_data[FREQ_W-1:0]      = freq_idx;
        OFF_ID:     rd_data                  = DATA_WIDTH'(ID_VALUE);
        default:    rd_data                  = '0;
      endcase
    end
  end

  // A read of EVENTS clears every flag, a write clears the flags whose
  // data bit is 1.
  always_comb begin
    clr_mask = '0;
    if (en && hit_events) begin
      clr_mask = we ? data[NUM_BUTTONS-1:0] : {NUM_BUTTONS{1'b1}};
    end
  end

  // The press pulses are OR-ed in after the clear so that an event
  // arriving on the same edge as a clear is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= '0;
      irq   <= 1'b0;
    end else begin
      flags <= (flags & ~clr_mask) | presses;
      irq   <= |flags;
    end
  end

  // Simultaneous LEFT and RIGHT presses cancel out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freq_idx <= '0;
    end else if (presses[EV_RIGHT] && !presses[EV_LEFT]) begin
      if (freq_idx != FREQ_LAST) freq_idx <= freq_idx + 1'b1;
    end else if (presses[EV_LEFT] && !presses[EV_RIGHT]) begin
      if (freq_idx != '0) freq_idx <= freq_idx - 1'b1;
    end
  end

  // Out-of-window reads load zero through rd_data's default
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (rd) begin
      q <= rd_data;
    end
  end

endmodule

// File: doc/morse_input_mem.md
Name: morse_input_mem

Overview:
- Memory-mapped read-side peripheral for the morse module. The CPU reads player inputs through it rather than writing outputs.
- Synchronizes and debounces the three morse panel buttons (LEFT, RIGHT, TX).
- Maintains a saturating frequency-selector index and sticky press-event flags.
- Returns register contents on the shared data bus with one-cycle read latency. Sits on the same address bus as the morse output window, directly above it.

Parameters:
- DATA_WIDTH, 16, bus data width
- ADDR_WIDTH, 16, bus address width
- BASE_ADDR, 16'he664, first address of this block's 4-word window
- DEBOUNCE_CYCLES, 50000, stable-sample count before a debounced level changes (1 ms at 50 MHz)
- FREQ_MAX, 15, maximum frequency index (minimum is 0)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- addr  input  ADDR_WIDTH  bus address
- data  input  DATA_WIDTH  bus write data (used only for write-1-to-clear)
- en  input  1  bus cycle enable
- we  input  1  1 = write, 0 = read
- btn_left  input  1  raw LEFT button, active-high, asynchronous to clk
- btn_right  input  1  raw RIGHT button, active-high, asynchronous to clk
- btn_tx  input  1  raw TX button, active-high, asynchronous to clk
- q  output  DATA_WIDTH  registered read data
- irq  output  1  high while any event flag is set

Behaviour:
- Reset (async, active-high): q=0, irq=0, synchronizers=0, debounced levels=0, debounce counters=0, event flags=0, freq_idx=0.
- Input path per button:
  - 2-FF synchronizer into a debounce counter.
  - The counter resets whenever the synchronized sample equals the current debounced level.
  - When it reaches DEBOUNCE_CYCLES-1 with the sample still differing, the debounced level toggles on the next edge and the counter clears.
  - Rising edge of a debounced level gives a one-cycle press pulse.
  - Glitches shorter than DEBOUNCE_CYCLES never reach the debounced level.
- Register map (offset from BASE_ADDR):
  - +0 LEVELS (RO): bits[2:0] = {tx, right, left} debounced levels; upper bits 0.
  - +1 EVENTS (R, clear-on-read; W1C): bits[2:0] = sticky press flags {tx, right, left}.
  - +2 FREQ (RO): bits[3:0] = freq_idx.
  - +3 ID (RO): constant 16'h4D53.
- Read path:
  - A read is en=1 and we=0. On that edge, q captures the addressed register.
  - The value is valid the following cycle (latency 1). q holds until the next read.
  - A read with an address outside [BASE_ADDR, BASE_ADDR+3] loads q=0.
  - en=0 leaves q unchanged.
- EVENTS clear-on-read:
  - q gets the pre-clear value and the flags clear on the same edge.
  - A press pulse arriving on that same edge sets its flag after the clear (set wins), so no event is lost.
- EVENTS write (en=1, we=1, addr=+1): flags where data bit=1 are cleared; a same-cycle press pulse wins.
- Writes to any other offset are ignored. Writes never change q.
- freq_idx:
  - RIGHT pulse increments, saturating at FREQ_MAX.
  - LEFT pulse decrements, saturating at 0.
  - Simultaneous LEFT and RIGHT pulses: no change, but both flags set.
- irq = OR of the event flags, registered (asserts one cycle after the flag sets).
- Reset mid-debounce discards partial counts. Reset mid-read forces q=0 immediately.

Decomposition:
- Shared package (morse_pkg) holds:
  - BASE_ADDR
  - register offset constants (OFF_LEVELS, OFF_EVENTS, OFF_FREQ, OFF_ID)
  - ID_VALUE
  - event bit indices (EV_LEFT=0, EV_RIGHT=1, EV_TX=2)
- Sub-module: debounce (per-button synchronizer, counter and level register, plus rise pulse), instantiated three times.

Test Plan:
- Reset, then read +3 -> q=16'h4D53 one cycle after the read edge. Read BASE_ADDR+4 -> q=0.
- Hold btn_tx high for DEBOUNCE_CYCLES+4 cycles (DEBOUNCE_CYCLES=8 in sim):
  - read +0 -> 16'h0004
  - read +1 -> 16'h0004, irq was 1
  - second read +1 -> 0, irq 0
- Pulse btn_right for 3 cycles (below threshold) -> LEVELS=0, EVENTS=0, FREQ=0.
- 20 debounced RIGHT presses -> FREQ reads 15; then 17 LEFT presses -> FREQ reads 0.
- Issue a read of +1 on the exact edge a LEFT press pulse fires -> q=0 (old value), next read of +1 -> 16'h0001.
- Set all three flags, write 16'h0005 to +1 -> read +1 -> 16'h0002. Assert reset mid-debounce -> all outputs 0 asynchronously.
